hilo_muldiv_unit: RTL and testbench
===================================

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, reset, synchronous active-high.
REQ-002 SHALL have ports: start input 1, request a new operation; op input 2, operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU); a input 32, rs operand; b input 32, rt operand.
REQ-003 SHALL have ports: cancel input 1, pipeline flush, aborts the operation in flight; mthi input 1, write HI; mtlo input 1, write LO; wdata input 32, MTHI/MTLO data.
REQ-004 SHALL have ports: busy output 1, operation in flight; stall_req output 1, stall request to the hazard unit; done output 1, one-cycle result-valid pulse.
REQ-005 SHALL have ports: prod output 64, {HI,LO} result, valid while done=1; hi output 32, architectural HI; lo output 32, architectural LO.

Function
REQ-006 SHALL implement the states IDLE, RUN and FIN.
REQ-007 SHALL, in IDLE with start=1 and cancel=0, latch op, |a|, |b| (magnitudes for signed ops) and the sign flags, clear the 6-bit iteration counter, and enter RUN.
REQ-008 SHALL perform exactly one shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle, for 32 cycles, then enter FIN.
REQ-009 SHALL, in FIN, set done=1 and drive prod with the sign-corrected result, write prod to hi/lo at the end of that cycle, and return to IDLE.
REQ-010 SHALL produce the following timing: start in cycle 0 -> RUN in cycles 1..32, FIN/done in cycle 33, new hi/lo visible in cycle 34.
REQ-011 SHALL form the result as follows: MULT = signed 64-bit product; MULTU = unsigned 64-bit product; DIV/DIVU give lo=quotient and hi=remainder.
REQ-012 SHALL, for signed division, negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-013 SHALL, on divide by zero, still use the full 33-cycle timing and produce lo=32'hFFFFFFFF, hi=a (original value); this applies to signed and unsigned divide.
REQ-014 SHALL drive busy=1 in RUN and FIN.
REQ-015 SHALL drive stall_req = busy | (start & ~cancel).
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL, when cancel=1 in any state, return to IDLE on the next edge with done=0 and hi/lo unchanged. cancel wins over a simultaneous start or FIN write.
REQ-018 SHALL write wdata to HI on mthi=1 and to LO on mtlo=1, but only in IDLE. Both may be written in the same cycle. MTHI/MTLO are ignored while busy=1.
REQ-019 SHALL let a start and an mthi/mtlo in the same IDLE cycle both take effect, with the FIN write winning later.
REQ-020 SHALL drive prod to 0 whenever done=0.

Reset
REQ-021 SHALL, on rst=1 at the clock edge, force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, stall_req=0 (except via start), prod=0.
REQ-022 SHALL have rst take priority over start, cancel, mthi and mtlo.
REQ-023 SHALL, on rst mid-operation, discard the operation with no done pulse.

Configuration
REQ-024 SHALL, when MULDIV_FAST_MUL_EN is defined, compute MULT/MULTU with a single-cycle combinational multiplier: start in cycle 0 -> FIN/done in cycle 1. Divide timing is unchanged.
REQ-025 SHALL, when MULDIV_FAST_MUL_EN is undefined, use the iterative multiply of REQ-008. Results are bit-identical in both builds.

Structure
REQ-026 SHALL take from a shared package muldiv_pkg: the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state encoding (ST_IDLE, ST_RUN, ST_FIN) and ITER_CNT=32.
REQ-027 SHALL place one step of the datapath in a sub-module muldiv_step: a combinational single-iteration shift-add / shift-subtract on a 65-bit accumulator. The FSM, counter, sign fix-up and HI/LO registers stay in hilo_muldiv_unit.

Verification
REQ-028 SHALL cover: MULT a=32'hFFFFFFFF, b=2 -> done in cycle 33, prod=64'hFFFFFFFF_FFFFFFFE; MULTU with the same operands -> prod=64'h00000001_FFFFFFFE.
REQ-029 SHALL cover: DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-030 SHALL cover: DIVU a=7, b=0 -> done in cycle 33, lo=32'hFFFFFFFF, hi=7.
REQ-031 SHALL cover: start MULT, then cancel in cycle 10 -> IDLE in cycle 11, no done pulse, hi/lo hold their prior values; a start in cycle 11 is accepted.
REQ-032 SHALL cover: mthi with wdata=32'h1234 while busy -> hi unchanged; in IDLE -> hi=32'h1234 next cycle. rst in cycle 20 of DIV -> hi=lo=0, busy=0, no done pulse.
REQ-033 SHALL cover: with MULDIV_FAST_MUL_EN defined, MULTU 32'h10000 x 32'h10000 -> done in cycle 1, prod=64'h00000001_00000000.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states, iteration count.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

    localparam int ITER_CNT = 32;

    // Bit 0 of the op code clear means a signed operation.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic [1:0] op);
        return (!op[0] && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
// Accumulator layout: [64:32] partial product / remainder, [31:0] multiplier / quotient.
import muldiv_pkg::*;

module muldiv_step (
    input  logic        is_div,
    input  logic [64:0] acc_in,
    input  logic [31:0] operand,
    output logic [64:0] acc_out
);
    logic [32:0] sum;
    logic [33:0] diff;

    always_comb begin
        sum  = acc_in[64:32] + {1'b0, operand};
        diff = {1'b0, acc_in[63:31]} - {2'b00, operand};
        if (is_div) begin
            acc_out = diff[33] ? {acc_in[63:0], 1'b0} : {diff[32:0], acc_in[30:0], 1'b1};
        end else begin
            acc_out = acc_in[0] ? {1'b0, sum, acc_in[31:1]} : {1'b0, acc_in[64:32], acc_in[31:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO: start -> done 33 cycles later.
// MULDIV_FAST_MUL_EN: single-cycle multiply (done 1 cycle after start); divide unchanged.
import muldiv_pkg::*;

module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [63:0] prod,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    logic [1:0]  state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic [31:0] a_q;
    logic [31:0] b_mag;
    logic [64:0] acc;
    logic [64:0] acc_nxt;
    logic [31:0] a_mag;
    logic [31:0] b_mag_in;
    logic [63:0] result;

    assign a_mag    = magnitude(a, op);
    assign b_mag_in = magnitude(b, op);

    muldiv_step u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .operand (b_mag),
        .acc_out (acc_nxt)
    );

    // Divide by zero bypasses sign fix-up: quotient all-ones, remainder is the raw dividend.
    always_comb begin
        result = 64'd0;
        if (is_div) begin
            if (b_mag == 32'd0) begin
                result = {a_q, 32'hFFFF_FFFF};
            end else begin
                result[31:0]  = neg_res ? -acc[31:0]  : acc[31:0];
                result[63:32] = neg_rem ? -acc[63:32] : acc[63:32];
            end
        end else begin
            result = neg_res ? -acc[63:0] : acc[63:0];
        end
    end

    assign busy      = (state != ST_IDLE);
    assign stall_req = busy | (start & ~cancel);
    assign done      = (state == ST_FIN) & ~cancel;
    assign prod      = done ? result : 64'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 6'd0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            a_q     <= 32'd0;
            b_mag   <= 32'd0;
            acc     <= 65'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (cancel) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= !op[0] && (a[31] ^ b[31]);
                        neg_rem <= !op[0] && a[31];
                        a_q     <= a;
                        b_mag   <= b_mag_in;
                        cnt     <= 6'd0;
                        acc     <= {33'd0, a_mag};
                        state   <= ST_RUN;
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[1]) begin
                            acc   <= {1'b0, 64'(a_mag) * 64'(b_mag_in)};
                            state <= ST_FIN;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(ITER_CNT - 1)) state <= ST_FIN;
                end
                ST_FIN: begin
                    hi    <= result[63:32];
                    lo    <= result[31:0];
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit: latency, results, cancel, reset, MTHI/MTLO.
module tb_hilo_muldiv_unit;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MULDIV_FAST_MUL_EN
    localparam int         MUL_LAT   = 1;
    localparam logic [1:0] CANCEL_OP = DIVU;
`else
    localparam int         MUL_LAT   = 33;
    localparam logic [1:0] CANCEL_OP = MULT;
`endif

    logic        clk = 1'b0;
    logic        rst, start, cancel, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, stall_req, done;
    logic [63:0] prod;
    logic [31:0] hi, lo;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int d0;

    hilo_muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .stall_req(stall_req), .done(done), .prod(prod), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives start in cycle 0, leaves the bench in cycle 1.
    task automatic start_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        op = o; a = av; b = bv; start = 1'b1;
        #1;
        chk("stall_on_start", stall_req, 1);
        chk("idle_before_start", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        cyc = 1;
        #1;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_op(input string tag, input int lat, input logic [63:0] exp);
        while (!done && cyc < 40) tick();
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_prod"}, prod, exp);
        tick();
        chk({tag, "_hi"}, hi, exp[63:32]);
        chk({tag, "_lo"}, lo, exp[31:0]);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_prod_zero"}, prod, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
        tick(); tick();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_prod", prod, 0);
        chk("rst_stall", stall_req, 0);
        rst = 1'b0;
        tick();

        start_op(MULT, 32'hFFFF_FFFF, 32'd2);
        finish_op("mult_m1x2", MUL_LAT, 64'hFFFF_FFFF_FFFF_FFFE);
        start_op(MULTU, 32'hFFFF_FFFF, 32'd2);
        finish_op("multu_ffx2", MUL_LAT, 64'h0000_0001_FFFF_FFFE);
        start_op(MULT, 32'hFFFF_FFFD, 32'd5);
        finish_op("mult_m3x5", MUL_LAT, 64'hFFFF_FFFF_FFFF_FFF1);
        start_op(MULTU, 32'h0001_0000, 32'h0001_0000);
        finish_op("multu_2p32", MUL_LAT, 64'h0000_0001_0000_0000);
        start_op(DIV, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_m7d2", 33, 64'hFFFF_FFFF_FFFF_FFFD);
        start_op(DIVU, 32'd7, 32'd2);
        finish_op("divu_7d2", 33, 64'h0000_0001_0000_0003);
        start_op(DIVU, 32'd7, 32'd0);
        finish_op("divu_by0", 33, 64'h0000_0007_FFFF_FFFF);
        start_op(DIV, 32'hFFFF_FFF9, 32'd0);
        finish_op("div_by0", 33, 64'hFFFF_FFF9_FFFF_FFFF);

        // A second start while busy must not disturb the running divide.
        start_op(DIV, 32'd100, 32'hFFFF_FFF9);
        tick(); tick(); tick();
        start = 1'b1; op = DIVU; a = 32'd1; b = 32'd1;
        #1;
        chk("stall_while_busy", stall_req, 1);
        tick();
        start = 1'b0;
        finish_op("div_100dm7", 33, 64'h0000_0002_FFFF_FFF2);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_0000;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        #1;
        chk("mthi_both", hi, 32'h5A5A_0000);
        chk("mtlo_both", lo, 32'h5A5A_0000);

        d0 = done_cnt;
        start_op(CANCEL_OP, 32'd3, 32'd4);
        repeat (9) tick();
        cancel = 1'b1;
        #1;
        chk("cancel_done_low", done, 0);
        tick();
        cancel = 1'b0;
        chk("cancel_idle", busy, 0);
        chk("cancel_hi_held", hi, 32'h5A5A_0000);
        chk("cancel_lo_held", lo, 32'h5A5A_0000);
        chk("cancel_no_done", 64'(done_cnt), 64'(d0));
        start_op(DIVU, 32'd9, 32'd4);
        finish_op("divu_after_cancel", 33, 64'h0000_0001_0000_0002);

        d0 = done_cnt;
        start_op(DIV, 32'd50, 32'd3);
        repeat (4) tick();
        mthi = 1'b1; wdata = 32'h0000_1234;
        tick();
        mthi = 1'b0;
        #1;
        chk("mthi_busy_ignored", hi, 32'h0000_0001);
        while (cyc < 20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_no_done", 64'(done_cnt), 64'(d0));

        mthi = 1'b1; wdata = 32'h0000_1234;
        tick();
        mthi = 1'b0;
        #1;
        chk("mthi_idle", hi, 32'h0000_1234);
        chk("mthi_lo_untouched", lo, 0);

        mtlo = 1'b1; wdata = 32'h0000_DEAD;
        start_op(MULTU, 32'd2, 32'd3);
        chk("mtlo_with_start", lo, 32'h0000_DEAD);
        finish_op("multu_2x3", MUL_LAT, 64'h0000_0000_0000_0006);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
